// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrated N:1 mux and its arbiter.
// Channel-index width helper, pointer reset offset and packet-lock state encoding.
package rr_arb_mux_pkg;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Pointer resets this many channels below NUM_CH so that channel 0 wins first.
   localparam int RST_PTR_BACKOFF = 1;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past last_grant, wrapping.
// grant is one-hot and only asserted when advance is high; grant_idx/found are always valid.
module rr_arbiter
   import rr_arb_mux_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = sel_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   input  logic [SEL_W-1:0]  last_grant,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              found
);

   int c;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      c         = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         c = (int'(last_grant) + k) % NUM_CH;
         if (!found && req[c]) begin
            found     = 1'b1;
            grant_idx = SEL_W'(c);
            grant[c]  = advance;
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready mux with round-robin arbitration and a registered one-entry output.
// Optional packet lock (in_last/out_last) is enabled by defining RR_ARB_MUX_PKT_LOCK_EN.
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = sel_w(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_sel,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
   input  logic [NUM_CH-1:0]        in_last,
   output logic                     out_last,
`endif
   input  logic                     out_ready
);

   logic              load_en;
   logic              found;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] grant;
   logic [SEL_W-1:0]  grant_idx;
   logic [SEL_W-1:0]  last_grant;
   logic [DATA_W-1:0] sel_data;

   assign load_en = !out_valid || out_ready;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
   lock_state_e lock_q;
   lock_state_e lock_d;

   // While locked, last_grant is the owning channel, so masking req to it suffices.
   always_comb begin
      req = in_valid;
      if (lock_q == LOCKED) begin
         req = in_valid & (NUM_CH'(1) << last_grant);
      end
   end

   always_comb begin
      lock_d = lock_q;
      if (load_en && found) begin
         lock_d = in_last[grant_idx] ? UNLOCKED : LOCKED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q <= UNLOCKED;
      end else begin
         lock_q <= lock_d;
      end
   end
`else
   assign req = in_valid;
`endif

   // Gating with rst_n drops in_ready asynchronously while reset is held.
   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arbiter (
      .req        (req),
      .advance    (load_en && rst_n),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .found      (found)
   );

   assign in_ready = grant;
   assign sel_data = in_data[grant_idx*DATA_W +: DATA_W];

   // Output register stage: loads on drain or empty, holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_sel    <= '0;
         last_grant <= SEL_W'(NUM_CH - RST_PTR_BACKOFF);
`ifdef RR_ARB_MUX_PKT_LOCK_EN
         out_last   <= 1'b0;
`endif
      end else if (load_en) begin
         out_valid <= found;
         if (found) begin
            out_data   <= sel_data;
            out_sel    <= grant_idx;
            last_grant <= grant_idx;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            out_last   <= in_last[grant_idx];
`endif
         end
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux (NUM_CH=4, DATA_W=8); covers RR_ARB_MUX_PKT_LOCK_EN when defined.
// Directed per-channel beat lists, hand-ordered expected beats, negedge monitor.
module tb_rr_arb_mux;

   localparam int NCH = 4;
   localparam int DW  = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    sel;
      logic          last;
   } beat_t;

   logic              clk;
   logic              rst_n;
   logic [NCH-1:0]    in_valid;
   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_sel;
   logic              out_ready;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
   logic [NCH-1:0]    in_last;
   logic              out_last;
   logic              plast [NCH][16];
`endif

   beat_t          sb[$];
   logic [DW-1:0]  pdat [NCH][16];
   int             phead [NCH];
   int             ptail [NCH];
   logic [NCH-1:0] acc;
   int             n_chk;
   int             n_fail;

   rr_arb_mux #(
      .NUM_CH (NCH),
      .DATA_W (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load(input int ch, input logic [DW-1:0] d, input logic l);
      pdat[ch][ptail[ch]] = d;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      plast[ch][ptail[ch]] = l;
`endif
      ptail[ch]++;
   endtask

   task automatic expect_beat(input logic [DW-1:0] d, input logic [1:0] s, input logic l);
      beat_t b;
      b.data = d;
      b.sel  = s;
      b.last = l;
      sb.push_back(b);
   endtask

   task automatic refresh();
      for (int i = 0; i < NCH; i++) begin
         if (phead[i] < ptail[i]) begin
            in_valid[i]         = 1'b1;
            in_data[i*DW +: DW] = pdat[i][phead[i]];
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            in_last[i]          = plast[i][phead[i]];
`endif
         end else begin
            in_valid[i]         = 1'b0;
            in_data[i*DW +: DW] = '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            in_last[i]          = 1'b0;
`endif
         end
      end
   endtask

   // Producers advance on handshakes seen at the preceding negedge; checks land at posedge+2.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
         if (acc[i]) phead[i]++;
      end
      refresh();
      #1;
   endtask

   always @(negedge clk) acc <= in_valid & in_ready;

   always @(negedge clk) begin
      beat_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", {24'h0, out_data}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("sb_data", {24'h0, out_data}, {24'h0, e.data});
            chk("sb_sel", {30'h0, out_sel}, {30'h0, e.sel});
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            chk("sb_last", {31'h0, out_last}, {31'h0, e.last});
`endif
         end
      end
   end

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      acc       = '0;
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in_valid  = '0;
      in_data   = '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      in_last   = '0;
`endif
      for (int i = 0; i < NCH; i++) begin
         phead[i] = 0;
         ptail[i] = 0;
      end

      // Reset with all channels valid, then a two-round full rotation.
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < NCH; i++) begin
            load(i, DW'(((i + 1) << 4) | b), 1'b1);
            expect_beat(DW'(((i + 1) << 4) | b), 2'(i), 1'b1);
         end
      end
      refresh();
      cycle();
      cycle();
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_in_ready", {28'h0, in_ready}, 32'h0);
      chk("rst_out_data", {24'h0, out_data}, 32'h0);
      chk("rst_out_sel", {30'h0, out_sel}, 32'h0);
      #1 rst_n = 1'b1;
      #1 chk("first_in_ready", {28'h0, in_ready}, 32'h1);
      cycle();
      chk("first_out_sel", {30'h0, out_sel}, 32'h0);
      chk("first_out_data", {24'h0, out_data}, 32'h10);
      chk("second_in_ready", {28'h0, in_ready}, 32'h2);
      for (int k = 1; k < 8; k++) begin
         cycle();
         chk("rot_out_valid", {31'h0, out_valid}, 32'h1);
         chk("rot_out_sel", {30'h0, out_sel}, k % NCH);
      end
      cycle();
      chk("rot_drained", {31'h0, out_valid}, 32'h0);

      // Stall: ch2 only, consumer not ready.
      out_ready = 1'b0;
      load(2, 8'hA5, 1'b1);
      load(2, 8'h5A, 1'b1);
      expect_beat(8'hA5, 2'd2, 1'b1);
      expect_beat(8'h5A, 2'd2, 1'b1);
      refresh();
      #1 chk("stall_grant", {28'h0, in_ready}, 32'h4);
      cycle();
      for (int k = 0; k < 3; k++) begin
         chk("stall_valid", {31'h0, out_valid}, 32'h1);
         chk("stall_data", {24'h0, out_data}, 32'hA5);
         chk("stall_sel", {30'h0, out_sel}, 32'h2);
         chk("stall_in_ready", {28'h0, in_ready}, 32'h0);
         cycle();
      end
      out_ready = 1'b1;
      #1 chk("drain_load_ready", {28'h0, in_ready}, 32'h4);
      cycle();
      chk("drain_load_data", {24'h0, out_data}, 32'h5A);
      chk("drain_load_valid", {31'h0, out_valid}, 32'h1);
      cycle();
      chk("stall_drained", {31'h0, out_valid}, 32'h0);

      // Wrap-around from last_grant=1 and pointer hold across idle cycles.
      load(1, 8'h61, 1'b1);
      expect_beat(8'h61, 2'd1, 1'b1);
      refresh();
      #1 chk("ptr_set_ready", {28'h0, in_ready}, 32'h2);
      cycle();
      cycle();
      cycle();
      chk("idle_valid", {31'h0, out_valid}, 32'h0);
      load(1, 8'h71, 1'b1);
      load(3, 8'h73, 1'b1);
      expect_beat(8'h73, 2'd3, 1'b1);
      expect_beat(8'h71, 2'd1, 1'b1);
      refresh();
      #1 chk("wrap_grant3", {28'h0, in_ready}, 32'h8);
      cycle();
      chk("wrap_sel3", {30'h0, out_sel}, 32'h3);
      chk("wrap_next_ready", {28'h0, in_ready}, 32'h2);
      cycle();
      chk("wrap_sel1", {30'h0, out_sel}, 32'h1);
      chk("wrap_data1", {24'h0, out_data}, 32'h71);
      cycle();

      // Asynchronous reset mid-stream drops the buffered ch2 beat (0x82).
      for (int i = 0; i < NCH; i++) load(i, DW'(8'h80 + i), 1'b1);
      expect_beat(8'h80, 2'd0, 1'b1);
      expect_beat(8'h81, 2'd1, 1'b1);
      expect_beat(8'h83, 2'd3, 1'b1);
      refresh();
      #1 chk("pre_rst_grant", {28'h0, in_ready}, 32'h4);
      cycle();
      chk("pre_rst_sel", {30'h0, out_sel}, 32'h2);
      #1 rst_n = 1'b0;
      #1 chk("async_out_valid", {31'h0, out_valid}, 32'h0);
      chk("async_in_ready", {28'h0, in_ready}, 32'h0);
      chk("async_out_data", {24'h0, out_data}, 32'h0);
      cycle();
      #1 rst_n = 1'b1;
      #1 chk("post_rst_ready", {28'h0, in_ready}, 32'h1);
      cycle();
      chk("post_rst_sel0", {30'h0, out_sel}, 32'h0);
      chk("post_rst_data", {24'h0, out_data}, 32'h80);
      cycle();
      chk("post_rst_sel1", {30'h0, out_sel}, 32'h1);
      cycle();
      chk("post_rst_sel3", {30'h0, out_sel}, 32'h3);
      cycle();
      chk("post_rst_drained", {31'h0, out_valid}, 32'h0);

`ifdef RR_ARB_MUX_PKT_LOCK_EN
      // ch0 three-beat packet locks out ch1 until the last beat.
      load(0, 8'hC0, 1'b0);
      load(0, 8'hC1, 1'b0);
      load(0, 8'hC2, 1'b1);
      load(1, 8'hD0, 1'b1);
      expect_beat(8'hC0, 2'd0, 1'b0);
      expect_beat(8'hC1, 2'd0, 1'b0);
      expect_beat(8'hC2, 2'd0, 1'b1);
      expect_beat(8'hD0, 2'd1, 1'b1);
      refresh();
      #1 chk("pkt_first_ready", {28'h0, in_ready}, 32'h1);
      cycle();
      chk("pkt_b0_sel", {30'h0, out_sel}, 32'h0);
      chk("pkt_b0_last", {31'h0, out_last}, 32'h0);
      chk("pkt_locked_ready", {28'h0, in_ready}, 32'h1);
      cycle();
      chk("pkt_b1_sel", {30'h0, out_sel}, 32'h0);
      cycle();
      chk("pkt_b2_sel", {30'h0, out_sel}, 32'h0);
      chk("pkt_b2_last", {31'h0, out_last}, 32'h1);
      chk("pkt_unlock_ready", {28'h0, in_ready}, 32'h2);
      cycle();
      chk("pkt_next_sel", {30'h0, out_sel}, 32'h1);
      cycle();
      chk("pkt_drained", {31'h0, out_valid}, 32'h0);
`endif

      chk("sb_empty", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
